// File: rtl/e15_run_ctrl.sv
// -----------------------------------------------------------------------------
// e15_run_ctrl -- run/step/load controller for a small core with a 4-bit PC
// and a 16 x 12-bit program ROM.
//
// Optional feature: define E15_BREAKPOINT_EN to add a PC breakpoint
// (ports brk_en, brk_addr). Without it, stop_cause 2'b00 is never reported.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (accepted when both are 1)
//   cmd_op[2:0]              000 LOAD, 001 RUN, 010 STEP, 011 STOP, 100 CONT
//   ld_addr[3:0], ld_data    ROM word written on LOAD
//   pc[3:0], instr[11:0]     core program counter and ROM[pc]
//   brk_en, brk_addr[3:0]    breakpoint (E15_BREAKPOINT_EN only)
//   core_en, core_rst        core clock-enable and core reset
//   rom_we/rom_waddr/wdata   program-ROM write port (one-cycle pulse)
//   busy, done               status: busy in CRST/RUN/STEP, done in DONE
//   stop_cause[1:0]          00 break, 01 halt, 10 timeout, 11 STOP
//   cycles[7:0]              enabled core cycles, saturating at 8'hFF
// -----------------------------------------------------------------------------
module e15_run_ctrl #(
  parameter logic [7:0] MAX_CYCLES = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  ld_addr,
  input  logic [11:0] ld_data,
  input  logic [3:0]  pc,
  input  logic [11:0] instr,
`ifdef E15_BREAKPOINT_EN
  input  logic        brk_en,
  input  logic [3:0]  brk_addr,
`endif
  output logic        core_en,
  output logic        core_rst,
  output logic        rom_we,
  output logic [3:0]  rom_waddr,
  output logic [11:0] rom_wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  stop_cause,
  output logic [7:0]  cycles
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_RUN  = 3'b001;
  localparam logic [2:0] OP_STEP = 3'b010;
  localparam logic [2:0] OP_STOP = 3'b011;
  localparam logic [2:0] OP_CONT = 3'b100;

  localparam logic [1:0] CAUSE_BRK     = 2'b00;
  localparam logic [1:0] CAUSE_HALT    = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_STOP    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CRST = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Status flags {cmd_ready, busy, done} registered alongside each state change.
  function automatic logic [2:0] state_flags(input state_t s);
    logic [2:0] f;
    case (s)
      S_IDLE:  f = 3'b100;
      S_CRST:  f = 3'b010;
      S_RUN:   f = 3'b110;
      S_STEP:  f = 3'b010;
      S_DONE:  f = 3'b101;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_stop_cause;
  logic [7:0]  r_cycles;
  logic        r_rom_we;
  logic [3:0]  r_rom_waddr;
  logic [11:0] r_rom_wdata;

  logic w_accept;
  logic w_stop_req;
  logic w_halt;
  logic w_timeout;
  logic w_brk;
  logic w_core_en;
  logic w_cmd_state;

  assign w_accept    = cmd_valid && r_cmd_ready;
  assign w_stop_req  = w_accept && (cmd_op == OP_STOP);
  // jmp 0 is a self-loop, so the program has nothing more to do
  assign w_halt      = (instr == 12'h000);
  assign w_timeout   = (r_cycles == MAX_CYCLES);
  assign w_cmd_state = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef E15_BREAKPOINT_EN
  logic r_brk_skip;

  // Arm a one-cycle breakpoint bypass on CONT so execution resumes past the stop PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brk_skip <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_brk_skip <= 1'b0;
    end else if (w_accept && w_cmd_state && (cmd_op == OP_CONT)) begin
      r_brk_skip <= 1'b1;
    end else begin
      r_brk_skip <= r_brk_skip;
    end
  end

  assign w_brk = brk_en && (pc == brk_addr) && !r_brk_skip;
`else
  // pc only matters to the breakpoint comparator
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_brk       = 1'b0;
`endif

  // Core clock-enable: free-running in RUN until a stop condition, one pulse in STEP.
  always_comb begin
    w_core_en = 1'b0;
    if (rst) begin
      w_core_en = 1'b0;
    end else begin
      case (r_state)
        S_RUN:   w_core_en = !w_halt && !w_timeout && !w_brk;
        S_STEP:  w_core_en = 1'b1;
        default: w_core_en = 1'b0;
      endcase
    end
  end

  // Control FSM with registered status, cycle counter and ROM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      {r_cmd_ready, r_busy, r_done} <= state_flags(S_IDLE);
      r_stop_cause <= 2'b00;
      r_cycles     <= 8'd0;
      r_rom_we     <= 1'b0;
      r_rom_waddr  <= 4'd0;
      r_rom_wdata  <= 12'd0;
    end else begin
      r_rom_we <= 1'b0;
      if (w_core_en && (r_cycles != 8'hFF)) begin
        r_cycles <= r_cycles + 8'd1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_LOAD: begin
                r_rom_we    <= 1'b1;
                r_rom_waddr <= ld_addr;
                r_rom_wdata <= ld_data;
              end
              OP_RUN: begin
                r_cycles <= 8'd0;
                r_state  <= S_CRST;
                {r_cmd_ready, r_busy, r_done} <= state_flags(S_CRST);
              end
              OP_STEP: begin
                r_state <= S_STEP;
                {r_cmd_ready, r_busy, r_done} <= state_flags(S_STEP);
              end
              OP_CONT: begin
                r_state <= S_RUN;
                {r_cmd_ready, r_busy, r_done} <= state_flags(S_RUN);
              end
              default: begin
                // STOP and undefined codes are accepted and ignored here
                r_state <= r_state;
              end
            endcase
          end
        end

        S_CRST: begin
          r_state <= S_RUN;
          {r_cmd_ready, r_busy, r_done} <= state_flags(S_RUN);
        end

        S_RUN: begin
          // STOP > halt > timeout > break; other commands are no-ops here
          if (w_stop_req) begin
            r_state      <= S_DONE;
            r_stop_cause <= CAUSE_STOP;
            {r_cmd_ready, r_busy, r_done} <= state_flags(S_DONE);
          end else if (w_halt) begin
            r_state      <= S_DONE;
            r_stop_cause <= CAUSE_HALT;
            {r_cmd_ready, r_busy, r_done} <= state_flags(S_DONE);
          end else if (w_timeout) begin
            r_state      <= S_DONE;
            r_stop_cause <= CAUSE_TIMEOUT;
            {r_cmd_ready, r_busy, r_done} <= state_flags(S_DONE);
          end else if (w_brk) begin
            r_state      <= S_DONE;
            r_stop_cause <= CAUSE_BRK;
            {r_cmd_ready, r_busy, r_done} <= state_flags(S_DONE);
          end else begin
            r_state <= S_RUN;
          end
        end

        S_STEP: begin
          r_state <= S_IDLE;
          {r_cmd_ready, r_busy, r_done} <= state_flags(S_IDLE);
        end

        default: begin
          r_state <= S_IDLE;
          {r_cmd_ready, r_busy, r_done} <= state_flags(S_IDLE);
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign core_en    = w_core_en;
  assign core_rst   = rst || (r_state == S_CRST);
  assign rom_we     = r_rom_we;
  assign rom_waddr  = r_rom_waddr;
  assign rom_wdata  = r_rom_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign stop_cause = r_stop_cause;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_e15_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_e15_run_ctrl -- scoreboard bench for e15_run_ctrl. A tiny core model
// (pc register + 16-word ROM fed by the DUT write port) closes the loop.
// Expected ROM writes and expected run results are queued when a command is
// issued and compared by a negedge monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_e15_run_ctrl;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_RUN  = 3'b001;
  localparam logic [2:0] OP_STEP = 3'b010;
  localparam logic [2:0] OP_STOP = 3'b011;
  localparam logic [2:0] OP_CONT = 3'b100;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  ld_addr;
  logic [11:0] ld_data;
  logic [3:0]  pc;
  logic [11:0] instr;
  logic        brk_en;
  logic [3:0]  brk_addr;
  logic        core_en;
  logic        core_rst;
  logic        rom_we;
  logic [3:0]  rom_waddr;
  logic [11:0] rom_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  stop_cause;
  logic [7:0]  cycles;

  e15_run_ctrl #(.MAX_CYCLES(8'd10)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .pc         (pc),
    .instr      (instr),
`ifdef E15_BREAKPOINT_EN
    .brk_en     (brk_en),
    .brk_addr   (brk_addr),
`endif
    .core_en    (core_en),
    .core_rst   (core_rst),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .busy       (busy),
    .done       (done),
    .stop_cause (stop_cause),
    .cycles     (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core model: ROM written by the DUT, pc advances by one per enabled cycle
  logic [11:0] rom [16];
  logic [3:0]  pc_m;
  always @(posedge clk) begin
    if (rom_we) rom[rom_waddr] <= rom_wdata;
    if (core_rst) pc_m <= 4'd0;
    else if (core_en) pc_m <= pc_m + 4'd1;
  end
  assign pc    = pc_m;
  assign instr = rom[pc_m];

  int n_vec  = 0;
  int n_miss = 0;
  int en_cnt  = 0;
  int rst_cnt = 0;
  int we_cnt  = 0;
  int n_loads = 0;

  logic [15:0] q_wr[$];
  logic [9:0]  q_done[$];
  logic        done_q = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: pop scoreboard on ROM writes and on the rising edge of done
  always @(negedge clk) begin
    if (core_en) en_cnt++;
    if (core_rst) rst_cnt++;
    if (rom_we) begin
      we_cnt++;
      check_eq("sb_wr_pending", 32'(q_wr.size() > 0), 32'd1);
      if (q_wr.size() > 0) check_eq("rom_write", {16'd0, rom_waddr, rom_wdata}, {16'd0, q_wr.pop_front()});
    end
    if (done && !done_q) begin
      check_eq("sb_done_pending", 32'(q_done.size() > 0), 32'd1);
      if (q_done.size() > 0) check_eq("run_result", {22'd0, stop_cause, cycles}, {22'd0, q_done.pop_front()});
    end
    done_q = done;
  end

  // caller is #1 after a posedge; returns #1 after the accepting posedge
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] a, input logic [11:0] d);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check_eq("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    ld_addr   = a;
    ld_data   = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [11:0] d);
    q_wr.push_back({a, d});
    n_loads++;
    do_cmd(OP_LOAD, a, d);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_timeout", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; ld_addr = 4'd0; ld_data = 12'd0;
    brk_en = 1'b0; brk_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("rst_core_en", {31'd0, core_en}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_cause", {30'd0, stop_cause}, 32'd0);
    check_eq("rst_cycles", {24'd0, cycles}, 32'd0);
    check_eq("rst_rom_we", {31'd0, rom_we}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("idle_core_rst", {31'd0, core_rst}, 32'd0);

    // program: every word non-zero except a halt at address 4
    for (int a = 0; a < 16; a++) begin
      logic [3:0] a4;
      a4 = 4'(a);
      load(a4, (a == 4) ? 12'h000 : {4'h8, a4, a4});
    end

    // single LOAD: one-cycle write, controller stays idle
    load(4'd3, 12'h9A5);
    check_eq("load_we_now", {31'd0, rom_we}, 32'd1);
    check_eq("load_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("load_idle_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    check_eq("load_we_1cyc", {31'd0, rom_we}, 32'd0);
    check_eq("load_idle_done", {31'd0, done}, 32'd0);

    // RUN to halt at pc 4
    en_cnt = 0; rst_cnt = 0;
    q_done.push_back({2'b01, 8'd4});
    do_cmd(OP_RUN, 4'd0, 12'd0);
    check_eq("crst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("crst_core_en", {31'd0, core_en}, 32'd0);
    check_eq("crst_busy", {31'd0, busy}, 32'd1);
    check_eq("crst_ready", {31'd0, cmd_ready}, 32'd0);
    wait_done();
    check_eq("halt_en_cnt", en_cnt, 32'd4);
    check_eq("halt_rst_cnt", rst_cnt, 32'd1);
    check_eq("halt_pc", {28'd0, pc}, 32'd4);
    check_eq("halt_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_hold", {29'd0, done, stop_cause}, {29'd0, 1'b1, 2'b01});

    // LOAD in DONE leaves DONE; then timeout run with no-op commands mid-run
    load(4'd4, 12'h444);
    @(posedge clk); #1;
    check_eq("load_in_done", {31'd0, done}, 32'd1);
    en_cnt = 0;
    q_done.push_back({2'b10, 8'd10});
    do_cmd(OP_RUN, 4'd0, 12'd0);
    do_cmd(OP_LOAD, 4'd5, 12'h000);
    do_cmd(OP_STEP, 4'd0, 12'd0);
    check_eq("run_noop_busy", {31'd0, busy}, 32'd1);
    wait_done();
    check_eq("tmo_en_cnt", en_cnt, 32'd10);
    check_eq("tmo_pc", {28'd0, pc}, 32'd10);

    // STOP and halt in the same (3rd) RUN cycle
    load(4'd2, 12'h000);
    q_done.push_back({2'b11, 8'd2});
    do_cmd(OP_RUN, 4'd0, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stop_halt_pc", {28'd0, pc}, 32'd2);
    do_cmd(OP_STOP, 4'd0, 12'd0);
    wait_done();

    // reset in the middle of a run
    load(4'd2, 12'h822);
    load(4'd4, 12'h000);
    do_cmd(OP_RUN, 4'd0, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("midrst_core_en", {31'd0, core_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_status", {27'd0, busy, done, stop_cause, core_en}, 32'd0);
    check_eq("midrst_cycles", {24'd0, cycles}, 32'd0);
    check_eq("midrst_rom_we", {31'd0, rom_we}, 32'd0);
    check_eq("midrst_pc", {28'd0, pc}, 32'd0);

    // two STEPs from IDLE
    en_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      do_cmd(OP_STEP, 4'd0, 12'd0);
      check_eq("step_en", {31'd0, core_en}, 32'd1);
      check_eq("step_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("step_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check_eq("step_back_idle", {30'd0, core_en, busy}, 32'd0);
    end
    check_eq("step_cycles", {24'd0, cycles}, 32'd2);
    check_eq("step_en_cnt", en_cnt, 32'd2);
    check_eq("step_pc", {28'd0, pc}, 32'd2);
    check_eq("step_done", {31'd0, done}, 32'd0);

    // CONT from pc 2 keeps cycles and skips the core reset
    en_cnt = 0; rst_cnt = 0;
    q_done.push_back({2'b01, 8'd4});
    do_cmd(OP_CONT, 4'd0, 12'd0);
    wait_done();
    check_eq("cont_en_cnt", en_cnt, 32'd2);
    check_eq("cont_rst_cnt", rst_cnt, 32'd0);

    // STOP and undefined opcodes in DONE are ignored
    do_cmd(3'b111, 4'd0, 12'd0);
    do_cmd(OP_STOP, 4'd0, 12'd0);
    @(posedge clk); #1;
    check_eq("ignored_in_done", {28'd0, done, busy, stop_cause}, {28'd0, 1'b1, 1'b0, 2'b01});

`ifdef E15_BREAKPOINT_EN
    // breakpoint at pc 2, then CONT resumes past it to the halt
    brk_en = 1'b1; brk_addr = 4'd2;
    q_done.push_back({2'b00, 8'd2});
    do_cmd(OP_RUN, 4'd0, 12'd0);
    wait_done();
    check_eq("brk_pc", {28'd0, pc}, 32'd2);
    en_cnt = 0;
    q_done.push_back({2'b01, 8'd4});
    do_cmd(OP_CONT, 4'd0, 12'd0);
    check_eq("brk_cont_en", {31'd0, core_en}, 32'd1);
    wait_done();
    check_eq("brk_cont_en_cnt", en_cnt, 32'd2);
    brk_en = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check_eq("we_pulses", we_cnt, n_loads);
    check_eq("sb_wr_left", q_wr.size(), 32'd0);
    check_eq("sb_done_left", q_done.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/e15_run_ctrl.md
E15_RUN_CTRL -- requirements
Module: e15_run_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 8'd200, which is the watchdog limit on enabled core cycles per run.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its posedge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit): command handshake; a command is accepted on a posedge where both are 1.
REQ-005 SHALL have port cmd_op, input, 3 bits: 000 LOAD, 001 RUN, 010 STEP, 011 STOP, 100 CONT; all other codes are accepted and ignored.
REQ-006 SHALL have ports ld_addr (input, 4 bits) and ld_data (input, 12 bits): the ROM word to write on LOAD.
REQ-007 SHALL have ports pc (input, 4 bits) and instr (input, 12 bits): the core's current program counter and ROM[pc].
REQ-008 SHALL have port core_en, output, 1 bit: core clock-enable; the core advances one instruction on each posedge where core_en=1.
REQ-009 SHALL have port core_rst, output, 1 bit: core reset, which forces the core's pc to 0.
REQ-010 SHALL have ports rom_we (output, 1 bit), rom_waddr (output, 4 bits) and rom_wdata (output, 12 bits): the program-ROM write port.
REQ-011 SHALL have ports busy (output, 1 bit), done (output, 1 bit), stop_cause (output, 2 bits) and cycles (output, 8 bits).

Function
REQ-012 SHALL implement the states IDLE, CRST, RUN, STEP and DONE.
REQ-013 SHALL drive cmd_ready=1 in IDLE, RUN and DONE, and cmd_ready=0 in CRST and STEP.
REQ-014 SHALL, when LOAD is accepted in IDLE or DONE, drive rom_we=1 for exactly the next cycle with the registered ld_addr and ld_data; the state is unchanged.
REQ-015 SHALL, when RUN is accepted in IDLE or DONE, clear cycles and go to CRST.
REQ-016 SHALL, in CRST, drive core_rst=1 and core_en=0 for one cycle and then go to RUN.
REQ-017 SHALL, when CONT is accepted in IDLE or DONE, go to RUN with no core_rst and with cycles retained.
REQ-018 SHALL, when STEP is accepted in IDLE or DONE, go to STEP; STEP drives core_en=1 for exactly one cycle and then returns to IDLE.
REQ-019 SHALL, in RUN, accept and act only on STOP; STOP causes DONE with stop_cause=11, and the core_en of the cycle in which STOP is accepted remains valid.
REQ-020 SHALL, in RUN, define the halt condition as instr==12'h000 (jmp with immediate 0, a self-loop).
REQ-021 SHALL, in RUN, drive core_en = !halt && !timeout_hit && !brk_hit combinationally from registered state plus pc/instr.
REQ-022 SHALL, on halt in RUN, drive core_en=0 in that cycle and go to DONE with stop_cause=01.
REQ-023 SHALL increment cycles on every posedge with core_en=1, saturating at 8'hFF.
REQ-024 SHALL, in RUN with cycles==MAX_CYCLES, hold core_en=0 and go to DONE with stop_cause=10.
REQ-025 SHALL resolve simultaneous stop events with priority STOP > halt > timeout > break.
REQ-026 SHALL drive busy=1 in CRST, RUN and STEP.
REQ-027 SHALL, in DONE, hold done=1 and stop_cause stable until the next accepted command.
REQ-028 SHALL treat LOAD, RUN, STEP and CONT accepted while in RUN as no-ops.

Reset
REQ-029 SHALL, on rst=1 at a posedge, set state=IDLE, cycles=0, stop_cause=00, done=0 and rom_we=0.
REQ-030 SHALL assert core_rst combinationally while rst=1.
REQ-031 SHALL, when reset occurs mid-RUN, drop core_en to 0 from the reset edge onward, with no write to ROM.

Configuration
REQ-032 SHALL, with E15_BREAKPOINT_EN defined, add input ports brk_en (1 bit) and brk_addr (4 bits).
REQ-033 SHALL, with E15_BREAKPOINT_EN defined, in RUN with brk_en=1 and pc==brk_addr, drive core_en=0 and go to DONE with stop_cause=00.
REQ-034 SHALL, with E15_BREAKPOINT_EN defined, suppress the breakpoint on the first RUN cycle after CONT so that execution resumes past it.
REQ-035 SHALL, without E15_BREAKPOINT_EN, omit the brk ports and logic, and stop_cause=00 SHALL never occur.

Verification
REQ-036 SHALL cover: LOAD addr 3, data 12'h9A5 -> rom_we=1 for exactly 1 cycle with rom_waddr=3 and rom_wdata=12'h9A5; state stays IDLE.
REQ-037 SHALL cover: RUN with pc=4 and instr at pc 4 equal to 12'h000 after 4 prior instructions -> core_rst for 1 cycle, then core_en=1 for 4 cycles, then done=1, stop_cause=01 and cycles=4.
REQ-038 SHALL cover: program with no halt and MAX_CYCLES=10 -> exactly 10 core_en cycles, then done=1, stop_cause=10 and cycles=10.
REQ-039 SHALL cover: STOP issued on the 3rd RUN cycle while halt is also true that cycle -> DONE with stop_cause=11 (STOP wins).
REQ-040 SHALL cover: STEP twice from IDLE -> core_en high for exactly 1 cycle each, cmd_ready=0 in the STEP cycle, and cycles=2.
REQ-041 SHALL cover: with E15_BREAKPOINT_EN, brk_addr=2 -> stop at pc=2 with stop_cause=00; then CONT -> core_en=1 at pc=2 and the run continues to halt.
